// File: rtl/hc_sr04_multi_cntr_pkg.sv
// Shared definitions for the multi-channel HC-SR04 ranger: one-hot state
// encoding and small constant helpers used to size counters.
package hc_sr04_multi_cntr_pkg;

    localparam int N_STATES = 7;

    typedef enum logic [N_STATES-1:0] {
        S_IDLE      = 7'b000_0001,
        S_TRIG      = 7'b000_0010,
        S_WAIT_RISE = 7'b000_0100,
        S_MEASURE   = 7'b000_1000,
        S_DONE      = 7'b001_0000,
        S_TIMEOUT   = 7'b010_0000,
        S_GAP       = 7'b100_0000
    } state_t;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    // Clocks per microsecond; SYS_FREQ is a whole number of MHz.
    function automatic int clk_per_us(input int sys_freq);
        return sys_freq / 1_000_000;
    endfunction

endpackage

// File: rtl/edge_detector_n.sv
// Two-flop synchroniser followed by a registered edge detector for one
// asynchronous input; edges are reported one cycle after synchronisation.
module edge_detector_n (
    input  logic clk,
    input  logic reset_n,
    input  logic cp,
    output logic p_edge,
    output logic n_edge
);

    logic sync_p0;
    logic sync_p1;
    logic prev_p2;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            prev_p2 <= 1'b0;
        end else begin
            sync_p0 <= cp;
            sync_p1 <= sync_p0;
            prev_p2 <= sync_p1;
        end
    end

    assign p_edge = sync_p1 & ~prev_p2;
    assign n_edge = ~sync_p1 & prev_p2;

endmodule

// File: rtl/hc_sr04_multi_cntr_usec_tick_gen.sv
// Microsecond prescaler: one-cycle tick at terminal count, restartable so
// every state starts its timing from a fresh microsecond boundary.
module usec_tick_gen
    import hc_sr04_multi_cntr_pkg::*;
#(
    parameter int SYS_FREQ = 100_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    output logic tick
);

    localparam int CLK_PER_US = clk_per_us(SYS_FREQ);
    localparam int CNT_W      = (CLK_PER_US > 1) ? clog2(CLK_PER_US) : 1;

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == CNT_W'(CLK_PER_US - 1));

    always_ff @(posedge clk) begin
        if (!reset_n || clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hc_sr04_multi_cntr.sv
// Round-robin HC-SR04 controller: triggers one sensor at a time, times its
// echo in microseconds and publishes a saturated centimetre distance per channel.
module hc_sr04_multi_cntr
    import hc_sr04_multi_cntr_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int SYS_FREQ   = 100_000_000,
    parameter int TRIG_US    = 10,
    parameter int TIMEOUT_US = 30_000,
    parameter int GAP_US     = 60_000,
    parameter int US_PER_CM  = 58,
    parameter int DIST_W     = 9,
    localparam int CH_W      = (N_CH > 1) ? clog2(N_CH) : 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic [N_CH-1:0]        echo,
    output logic [N_CH-1:0]        trig,
    output logic [N_CH*DIST_W-1:0] distance,
    output logic [N_CH-1:0]        dist_valid,
    output logic [N_CH-1:0]        timeout,
    output logic                   sample_strobe,
    output logic [CH_W-1:0]        sample_ch
);

    localparam int MAX_A = (TRIG_US > TIMEOUT_US) ? TRIG_US : TIMEOUT_US;
    localparam int MAX_US = (MAX_A > GAP_US) ? MAX_A : GAP_US;
    localparam int US_W   = clog2(MAX_US + 1);
    localparam int SUB_W  = (US_PER_CM > 1) ? clog2(US_PER_CM) : 1;

    state_t state;
    state_t state_next;
    logic   state_chg;

    logic [CH_W-1:0]  ch;
    logic [US_W-1:0]  us_cnt;
    logic [SUB_W-1:0] sub_cnt;
    logic [SUB_W-1:0] sub_nxt;
    logic [DIST_W-1:0] cm_cnt;
    logic [DIST_W-1:0] cm_nxt;
    logic             tick;

    logic [N_CH-1:0] rise_all;
    logic [N_CH-1:0] fall_all;
    logic            rise_sel;
    logic            fall_sel;

    logic [N_CH-1:0][DIST_W-1:0] dist_q;
    logic [N_CH-1:0]             valid_q;
    logic [N_CH-1:0]             tout_q;

    function automatic logic [DIST_W-1:0] sat_inc(input logic [DIST_W-1:0] v);
        return (v == {DIST_W{1'b1}}) ? v : v + DIST_W'(1);
    endfunction

    // Echo synchronisation and edge detection, one per sensor pin
    for (genvar k = 0; k < N_CH; k++) begin : g_echo
        edge_detector_n u_edge (
            .clk     (clk),
            .reset_n (reset_n),
            .cp      (echo[k]),
            .p_edge  (rise_all[k]),
            .n_edge  (fall_all[k])
        );
    end

    assign rise_sel  = rise_all[ch];
    assign fall_sel  = fall_all[ch];
    assign state_chg = (state_next != state);

    usec_tick_gen #(
        .SYS_FREQ (SYS_FREQ)
    ) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (state_chg),
        .tick    (tick)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (enable) state_next = S_TRIG;
            end
            S_TRIG: begin
                if (tick && us_cnt == US_W'(TRIG_US - 1)) state_next = S_WAIT_RISE;
            end
            S_WAIT_RISE: begin
                if (rise_sel) state_next = S_MEASURE;
                else if (tick && us_cnt == US_W'(TIMEOUT_US - 1)) state_next = S_TIMEOUT;
            end
            S_MEASURE: begin
                if (fall_sel) state_next = S_DONE;
                else if (tick && us_cnt == US_W'(TIMEOUT_US - 1)) state_next = S_TIMEOUT;
            end
            S_DONE, S_TIMEOUT: begin
                state_next = S_GAP;
            end
            S_GAP: begin
                if (tick && us_cnt == US_W'(GAP_US - 1)) state_next = enable ? S_TRIG : S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // The final microsecond of the echo lands on the same edge that enters
    // S_DONE, so results are taken from the next-value of the accumulator.
    always_comb begin
        sub_nxt = sub_cnt;
        cm_nxt  = cm_cnt;
        if (state == S_MEASURE && tick) begin
            if (sub_cnt == SUB_W'(US_PER_CM - 1)) begin
                sub_nxt = '0;
                cm_nxt  = sat_inc(cm_cnt);
            end else begin
                sub_nxt = sub_cnt + SUB_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            us_cnt  <= '0;
            sub_cnt <= '0;
            cm_cnt  <= '0;
            ch      <= '0;
        end else begin
            if (state_chg) us_cnt <= '0;
            else if (tick) us_cnt <= us_cnt + US_W'(1);

            if (state_next == S_MEASURE && state != S_MEASURE) begin
                sub_cnt <= '0;
                cm_cnt  <= '0;
            end else begin
                sub_cnt <= sub_nxt;
                cm_cnt  <= cm_nxt;
            end

            if (state == S_GAP && state_chg) begin
                ch <= (ch == CH_W'(N_CH - 1)) ? '0 : ch + CH_W'(1);
            end
        end
    end

    // Results are written on entry so they are visible with sample_strobe
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            dist_q  <= '0;
            valid_q <= '0;
            tout_q  <= '0;
        end else if (state_next == S_DONE) begin
            dist_q[ch]  <= cm_nxt;
            valid_q[ch] <= 1'b1;
            tout_q[ch]  <= 1'b0;
        end else if (state_next == S_TIMEOUT) begin
            dist_q[ch]  <= '1;
            valid_q[ch] <= 1'b0;
            tout_q[ch]  <= 1'b1;
        end
    end

    always_comb begin
        trig = '0;
        if (state == S_TRIG) trig[ch] = 1'b1;
    end

    assign sample_strobe = (state == S_DONE) || (state == S_TIMEOUT);
    assign sample_ch     = ch;
    assign distance      = dist_q;
    assign dist_valid    = valid_q;
    assign timeout       = tout_q;

endmodule

// File: tb/tb_hc_sr04_multi_cntr.sv
// Randomised self-checking bench for hc_sr04_multi_cntr at 1 clk = 1 us,
// with a second instance sized for saturation and stuck-high echoes.
module tb_hc_sr04_multi_cntr;

    localparam int N_CH       = 4;
    localparam int TRIG_US    = 10;
    localparam int TIMEOUT_US = 1000;
    localparam int GAP_US     = 50;
    localparam int US_PER_CM  = 58;
    localparam int DIST_W     = 9;
    localparam int DIST_MAX   = (1 << DIST_W) - 1;
    localparam int SAT_TOUT   = 40_000;

    localparam int M_ECHO  = 0;
    localparam int M_NONE  = 1;
    localparam int M_STUCK = 2;
    localparam int M_HOLD  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   reset_n;
    logic                   enable;
    logic [N_CH-1:0]        echo;
    logic [N_CH-1:0]        trig;
    logic [N_CH*DIST_W-1:0] distance;
    logic [N_CH-1:0]        dist_valid;
    logic [N_CH-1:0]        timeout;
    logic                   sample_strobe;
    logic [1:0]             sample_ch;

    logic                 sat_rst_n;
    logic                 sat_en;
    logic [1:0]           sat_echo;
    logic [1:0]           sat_trig;
    logic [2*DIST_W-1:0]  sat_distance;
    logic [1:0]           sat_valid;
    logic [1:0]           sat_tout;
    logic                 sat_strobe;
    logic                 sat_ch;

    hc_sr04_multi_cntr #(
        .N_CH(N_CH), .SYS_FREQ(1_000_000), .TRIG_US(TRIG_US), .TIMEOUT_US(TIMEOUT_US),
        .GAP_US(GAP_US), .US_PER_CM(US_PER_CM), .DIST_W(DIST_W)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .echo(echo), .trig(trig),
        .distance(distance), .dist_valid(dist_valid), .timeout(timeout),
        .sample_strobe(sample_strobe), .sample_ch(sample_ch)
    );

    hc_sr04_multi_cntr #(
        .N_CH(2), .SYS_FREQ(1_000_000), .TRIG_US(TRIG_US), .TIMEOUT_US(SAT_TOUT),
        .GAP_US(GAP_US), .US_PER_CM(US_PER_CM), .DIST_W(DIST_W)
    ) dut_sat (
        .clk(clk), .reset_n(sat_rst_n), .enable(sat_en), .echo(sat_echo), .trig(sat_trig),
        .distance(sat_distance), .dist_valid(sat_valid), .timeout(sat_tout),
        .sample_strobe(sat_strobe), .sample_ch(sat_ch)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_checks = 0;
    int   n_errors = 0;
    int   onehot_viol = 0;
    int   dbl_strobe = 0;
    logic strobe_q = 1'b0;
    logic sat_strobe_q = 1'b0;

    always @(negedge clk) begin
        if ($countones(trig) > 1 || $countones(sat_trig) > 1) onehot_viol <= onehot_viol + 1;
        if ((sample_strobe && strobe_q) || (sat_strobe && sat_strobe_q)) dbl_strobe <= dbl_strobe + 1;
        strobe_q     <= sample_strobe;
        sat_strobe_q <= sat_strobe;
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: whole centimetres of echo-high time, clipped to the field width
    function automatic int model_cm(input int h_us);
        int d;
        d = h_us / US_PER_CM;
        return (d > DIST_MAX) ? DIST_MAX : d;
    endfunction

    int sb_dist[N_CH];
    bit sb_valid[N_CH];
    bit sb_tout[N_CH];
    int exp_rise = -1;

    task automatic sb_clear();
        for (int j = 0; j < N_CH; j++) begin
            sb_dist[j]  = 0;
            sb_valid[j] = 1'b0;
            sb_tout[j]  = 1'b0;
        end
    endtask

    task automatic check_all_results();
        for (int j = 0; j < N_CH; j++) begin
            check($sformatf("dist%0d", j), distance[j*DIST_W +: DIST_W], sb_dist[j]);
            check($sformatf("valid%0d", j), dist_valid[j], sb_valid[j]);
            check($sformatf("tout%0d", j), timeout[j], sb_tout[j]);
        end
    endtask

    task automatic run_ch(input int k, input int mode, input int d, input int h, input bit drop_en);
        int n;
        int t_fall;
        int exp_s;
        n = 0;
        while (trig == '0 && n < 2000) begin step(); n++; end
        check("trig_sel", trig, 1 << k);
        if (exp_rise >= 0) check("trig_time", cyc, exp_rise);
        if (mode == M_STUCK) echo[k] = 1'b1;
        n = 0;
        while (trig != '0 && n < 100) begin step(); n++; end
        check("trig_width", n, TRIG_US);
        t_fall = cyc;
        if (mode == M_ECHO) begin
            repeat (d) step();
            echo[k] = 1'b1;
            for (int i = 0; i < h; i++) begin
                step();
                if (drop_en && i == h / 2) enable = 1'b0;
            end
            echo[k] = 1'b0;
            exp_s = t_fall + d + h + 3;
        end else if (mode == M_HOLD) begin
            repeat (d) step();
            echo[k] = 1'b1;
            exp_s = t_fall + d + 3 + TIMEOUT_US;
        end else begin
            exp_s = t_fall + TIMEOUT_US;
        end
        n = 0;
        while (!sample_strobe && n < 3000) begin step(); n++; end
        check("strobe_seen", sample_strobe, 1);
        check("strobe_time", cyc, exp_s);
        check("sample_ch", sample_ch, k);
        if (mode == M_ECHO) begin
            sb_dist[k] = model_cm(h); sb_valid[k] = 1'b1; sb_tout[k] = 1'b0;
        end else begin
            sb_dist[k] = DIST_MAX; sb_valid[k] = 1'b0; sb_tout[k] = 1'b1;
        end
        check_all_results();
        step();
        check("strobe_1cyc", sample_strobe, 0);
        echo[k] = 1'b0;
        exp_rise = enable ? exp_s + 1 + GAP_US : -1;
    endtask

    task automatic main_seq();
        int n;
        int r;
        int mode;
        reset_n = 1'b0;
        enable  = 1'b1;
        echo    = '0;
        sb_clear();
        repeat (3) step();
        check("rst_trig", trig, 0);
        check("rst_dist", distance, 0);
        check("rst_valid", dist_valid, 0);
        check("rst_tout", timeout, 0);
        check("rst_strobe", sample_strobe, 0);
        check("rst_ch", sample_ch, 0);
        reset_n = 1'b1;
        step();
        check("trig_after_rst", trig, 1);

        run_ch(0, M_ECHO, 100, 580, 1'b0);
        run_ch(1, M_NONE, 0, 0, 1'b0);
        run_ch(2, M_ECHO, $urandom_range(0, 60), 348, 1'b0);
        run_ch(3, M_STUCK, 0, 0, 1'b0);

        run_ch(0, M_ECHO, $urandom_range(0, 60), 116, 1'b0);
        run_ch(1, M_ECHO, $urandom_range(0, 60), 232, 1'b0);
        run_ch(2, M_ECHO, $urandom_range(0, 60), 348, 1'b0);
        run_ch(3, M_ECHO, $urandom_range(0, 60), 464, 1'b0);

        for (int i = 0; i < 8; i++) begin
            r = $urandom_range(0, 9);
            mode = (r < 6) ? M_ECHO : (r < 8) ? M_NONE : (r == 8) ? M_STUCK : M_HOLD;
            run_ch(i % N_CH, mode, $urandom_range(0, 80), $urandom_range(1, 990), 1'b0);
        end

        run_ch(0, M_ECHO, 20, 57, 1'b1);
        n = 0;
        repeat (GAP_US + 200) begin
            step();
            if (trig != '0) n++;
        end
        check("idle_no_trig", n, 0);
        enable = 1'b1;
        step();
        check("trig_resume", trig, 2);
        run_ch(1, M_ECHO, 5, 58, 1'b0);

        n = 0;
        while (trig == '0 && n < 2000) begin step(); n++; end
        check("rst_mid_sel", trig, 4);
        n = 0;
        while (trig != '0 && n < 100) begin step(); n++; end
        repeat (3) step();
        echo[2] = 1'b1;
        repeat (50) step();
        reset_n = 1'b0;
        step();
        check("mid_rst_trig", trig, 0);
        check("mid_rst_dist", distance, 0);
        check("mid_rst_valid", dist_valid, 0);
        check("mid_rst_tout", timeout, 0);
        check("mid_rst_strobe", sample_strobe, 0);
        check("mid_rst_ch", sample_ch, 0);
        echo[2] = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        check("trig_after_rst2", trig, 1);
        sb_clear();
        exp_rise = -1;
        run_ch(0, M_ECHO, $urandom_range(0, 40), $urandom_range(1, 990), 1'b0);
    endtask

    task automatic sat_seq();
        int n;
        int t_fall;
        int exp_s;
        sat_rst_n = 1'b0;
        sat_en    = 1'b1;
        sat_echo  = '0;
        repeat (3) step();
        sat_rst_n = 1'b1;
        n = 0;
        while (sat_trig == '0 && n < 100) begin step(); n++; end
        check("sat_trig0", sat_trig, 1);
        n = 0;
        while (sat_trig != '0 && n < 100) begin step(); n++; end
        t_fall = cyc;
        repeat (5) step();
        sat_echo[0] = 1'b1;
        repeat (34_800) step();
        sat_echo[0] = 1'b0;
        exp_s = t_fall + 5 + 34_800 + 3;
        n = 0;
        while (!sat_strobe && n < 100) begin step(); n++; end
        check("sat_strobe_time0", cyc, exp_s);
        check("sat_dist0", sat_distance[DIST_W-1:0], model_cm(34_800));
        check("sat_valid0", sat_valid[0], 1);
        check("sat_tout0", sat_tout[0], 0);

        n = 0;
        while (sat_trig == '0 && n < GAP_US + 100) begin step(); n++; end
        check("sat_trig1", sat_trig, 2);
        n = 0;
        while (sat_trig != '0 && n < 100) begin step(); n++; end
        t_fall = cyc;
        repeat (2) step();
        sat_echo[1] = 1'b1;
        exp_s = t_fall + 2 + 3 + SAT_TOUT;
        n = 0;
        while (!sat_strobe && n < SAT_TOUT + 1000) begin step(); n++; end
        check("sat_strobe_time1", cyc, exp_s);
        check("sat_ch1", sat_ch, 1);
        check("sat_dist1", sat_distance[2*DIST_W-1:DIST_W], DIST_MAX);
        check("sat_valid1", sat_valid[1], 0);
        check("sat_tout1", sat_tout[1], 1);
        check("sat_hold_dist0", sat_distance[DIST_W-1:0], DIST_MAX);
        check("sat_hold_valid0", sat_valid[0], 1);
        sat_en = 1'b0;
    endtask

    initial begin
        repeat (99_000) @(posedge clk);
        $display("FAIL watchdog: cycle %0d reached, expected completion earlier", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        fork
            main_seq();
            sat_seq();
        join
        step();
        check("trig_onehot_viol", onehot_viol, 0);
        check("strobe_back_to_back", dbl_strobe, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
